// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-RAM arbiter.
//   arb_state_t : arbiter FSM state (IDLE issues grants, RD_WAIT waits for
//                 the RAM read data, ACK is the host completion cycle).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        ACK
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// starve_counter: saturating host-wait counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : clear to zero (takes priority over inc)
//   inc          : count up by one, holding at max_wait
//   at_max       : count has reached max_wait
module starve_counter #(
    parameter int unsigned max_wait = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int unsigned cw = $clog2(max_wait + 1);

    logic [cw-1:0] count;

    assign at_max = (count == cw'(max_wait));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data RAM between the core
// (TOS-addressed load/store) and a host/debug port. Host accesses use free
// cycles, or steal one cycle from a busy core after max_wait cycles of waiting.
//   core_mem_read/write, core_daddr, core_dD : core memory request
//   core_mem_read_g/write_g                  : core enables, gated on a steal
//   wait_state                               : core stall (combinational)
//   host_req/we/addr/wdata                   : host request, held until ack
//   host_ack, host_rdata                     : completion pulse and read data
//   daddr, dwrite, dD, dQ                    : RAM port (dQ one cycle late)
module dmem_arbiter #(
    parameter int unsigned width       = 16,
    parameter int unsigned daddr_width = 8,
    parameter int unsigned max_wait    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   core_mem_read,
    input  logic                   core_mem_write,
    input  logic [daddr_width-1:0] core_daddr,
    input  logic [width-1:0]       core_dD,
    output logic                   core_mem_read_g,
    output logic                   core_mem_write_g,
    output logic                   wait_state,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [daddr_width-1:0] host_addr,
    input  logic [width-1:0]       host_wdata,
    output logic                   host_ack,
    output logic [width-1:0]       host_rdata,
    output logic [daddr_width-1:0] daddr,
    output logic                   dwrite,
    output logic [width-1:0]       dD,
    input  logic [width-1:0]       dQ
);

    import dmem_arb_pkg::*;

    arb_state_t state;
    logic       core_busy;
    logic       rd_pending;
    logic       grant;
    logic       forced;
    logic       at_max;

    assign core_busy = core_mem_read | core_mem_write;

    // rd_pending marks the cycle in which the core consumes dQ from its own
    // read; stealing the port then would hand it the host's data instead.
    assign grant  = (state == IDLE) && host_req && !rd_pending &&
                    (!core_busy || at_max);
    assign forced = grant && core_busy;

    assign wait_state       = forced;
    assign core_mem_read_g  = core_mem_read  && !forced;
    assign core_mem_write_g = core_mem_write && !forced;

    assign daddr  = grant ? host_addr  : core_daddr;
    assign dwrite = grant ? host_we    : core_mem_write_g;
    assign dD     = grant ? host_wdata : core_dD;

    starve_counter #(
        .max_wait(max_wait)
    ) u_starve (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (grant),
        .inc    ((state == IDLE) && host_req && !grant),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rd_pending <= 1'b0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            rd_pending <= core_mem_read_g;
            host_ack   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        if (host_we) begin
                            state    <= ACK;
                            host_ack <= 1'b1;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    host_rdata <= dQ;
                    host_ack   <= 1'b1;
                    state      <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// synchronous RAM. Host read results are queued when a request is issued and
// compared when host_ack appears.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        core_mem_read = 1'b0;
    logic        core_mem_write = 1'b0;
    logic [7:0]  core_daddr = '0;
    logic [15:0] core_dD = '0;
    logic        core_mem_read_g;
    logic        core_mem_write_g;
    logic        wait_state;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic [7:0]  daddr;
    logic        dwrite;
    logic [15:0] dD;
    logic [15:0] dQ;

    logic [15:0] mem [256];

    typedef struct {
        logic        we;
        logic [15:0] data;
    } sb_t;

    sb_t sb [$];
    int  n_cmp = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .width      (16),
        .daddr_width(8),
        .max_wait   (4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .core_mem_read   (core_mem_read),
        .core_mem_write  (core_mem_write),
        .core_daddr      (core_daddr),
        .core_dD         (core_dD),
        .core_mem_read_g (core_mem_read_g),
        .core_mem_write_g(core_mem_write_g),
        .wait_state      (wait_state),
        .host_req        (host_req),
        .host_we         (host_we),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .host_ack        (host_ack),
        .host_rdata      (host_rdata),
        .daddr           (daddr),
        .dwrite          (dwrite),
        .dD              (dD),
        .dQ              (dQ)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (dwrite) mem[daddr] <= dD;
        dQ <= mem[daddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every host_ack must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset_n && host_ack) begin
            if (sb.size() == 0) begin
                check("ack_unexpected", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (!e.we) check("host_rdata", {16'd0, host_rdata}, {16'd0, e.data});
            end
        end
    end

    // One host access with the core either idle or writing core_a/core_d every
    // cycle; rd_at >= 0 replaces that cycle's write with a core read of 0x10.
    task automatic run_host(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp_rdata, input bit busy,
                            input logic [7:0] core_a, input logic [15:0] core_d,
                            input int rd_at, input logic [15:0] exp_tos,
                            input int exp_grant, input int exp_lat, input int exp_stalls);
        int lat    = -1;
        int stalls = 0;
        int leaks  = 0;
        sb_t e;
        e.we = we;
        e.data = exp_rdata;
        sb.push_back(e);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            core_mem_write = busy && (i != rd_at);
            core_mem_read  = (i == rd_at);
            core_daddr     = (i == rd_at) ? 8'h10 : core_a;
            core_dD        = core_d;
            @(negedge clk);
            if (wait_state) stalls++;
            else if (core_mem_write_g !== core_mem_write || core_mem_read_g !== core_mem_read) leaks++;
            if (i == exp_grant) begin
                check("grant_wait_state", {31'd0, wait_state}, {31'd0, busy});
                check("grant_daddr", {24'd0, daddr}, {24'd0, addr});
                check("grant_dwrite", {31'd0, dwrite}, {31'd0, we});
                if (we) check("grant_dD", {16'd0, dD}, {16'd0, wdata});
                if (busy) check("grant_core_wr_g", {31'd0, core_mem_write_g}, 32'd0);
            end
            if (rd_at >= 0 && i == rd_at + 1) check("tos_dQ", {16'd0, dQ}, {16'd0, exp_tos});
            if (host_ack) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("ack_latency", lat, exp_lat);
        check("stall_cycles", stalls, exp_stalls);
        check("gate_leak", leaks, 0);
        @(posedge clk);
        #1;
        host_req       = 1'b0;
        core_mem_write = 1'b0;
        core_mem_read  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state: gating passes core enables through, no stall, no ack.
        core_mem_read  = 1'b1;
        core_mem_write = 1'b1;
        @(negedge clk);
        check("rst_wait_state", {31'd0, wait_state}, 32'd0);
        check("rst_read_g", {31'd0, core_mem_read_g}, 32'd1);
        check("rst_write_g", {31'd0, core_mem_write_g}, 32'd1);
        check("rst_host_ack", {31'd0, host_ack}, 32'd0);
        check("rst_host_rdata", {16'd0, host_rdata}, 32'd0);
        core_mem_read  = 1'b0;
        core_mem_write = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle core: free write then free read back.
        run_host(1'b1, 8'h10, 16'h1234, 16'h0000, 1'b0, 8'h30, 16'hAAAA, -1, 16'h0, 0, 1, 0);
        run_host(1'b0, 8'h10, 16'h0000, 16'h1234, 1'b0, 8'h30, 16'hAAAA, -1, 16'h0, 0, 2, 0);

        // Busy core: forced steal on the fifth cycle.
        run_host(1'b0, 8'h10, 16'h0000, 16'h1234, 1'b1, 8'h30, 16'hAAAA, -1, 16'h0, 4, 6, 1);

        // Core read just before the steal would fire: grant slips one cycle.
        run_host(1'b0, 8'h10, 16'h0000, 16'h1234, 1'b1, 8'h30, 16'hAAAA, 3, 16'h1234, 5, 7, 1);

        // Host and core write the same address: the core's retry wins.
        run_host(1'b1, 8'h20, 16'h5555, 16'h0000, 1'b1, 8'h20, 16'hBEEF, -1, 16'h0, 4, 5, 1);
        check("same_addr_mem", {16'd0, mem[8'h20]}, 32'h0000BEEF);
        run_host(1'b0, 8'h20, 16'h0000, 16'hBEEF, 1'b0, 8'h30, 16'hAAAA, -1, 16'h0, 0, 2, 0);

        // Reset during RD_WAIT abandons the access.
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h10;
        @(posedge clk);
        #1;
        #1;
        reset_n  = 1'b0;
        host_req = 1'b0;
        @(negedge clk);
        check("mid_rst_host_ack", {31'd0, host_ack}, 32'd0);
        check("mid_rst_host_rdata", {16'd0, host_rdata}, 32'd0);
        check("mid_rst_wait_state", {31'd0, wait_state}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_host_ack2", {31'd0, host_ack}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_host(1'b0, 8'h10, 16'h0000, 16'h1234, 1'b0, 8'h30, 16'hAAAA, -1, 16'h0, 0, 2, 0);

        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
